// File: rtl/periferico_multicanal.sv
// Multi-channel peripheral receiver: 4-phase send/ack per CPU channel, captured words tagged and queued in one shared FIFO.
// Latency: inSend rise -> outAck rise = SYNC_STAGES+1 clkPER cycles uncontended; pushed word visible at outValid the cycle after capture.
// Backpressure: no capture while the FIFO is full and not popping; the request stays pending with outAck held low.
//
// Ports:
//   clkPER, rstPER (async, active-low)
//   inSend[NCH], inData[NCH*DW]  per-channel request level and data (channel c at [c*DW +: DW])
//   outAck[NCH]                  per-channel acknowledge (registered)
//   outValid, outData, outChan   registered FIFO head; popped when outValid & inReady
//   inReady                      consumer ready
//   outCount                     FIFO occupancy 0..DEPTH
// Optional feature, macro PER_PARITY_EN: adds inParity[NCH] (even parity per channel) and
// sticky outParErr; a capture with bad parity completes the handshake but is not queued.
module periferico_multicanal #(
    parameter int NCH         = 2,
    parameter int DW          = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clkPER,
    input  logic              rstPER,
    input  logic [NCH-1:0]    inSend,
    input  logic [NCH*DW-1:0] inData,
`ifdef PER_PARITY_EN
    input  logic [NCH-1:0]    inParity,
    output logic              outParErr,
`endif
    output logic [NCH-1:0]    outAck,
    output logic              outValid,
    output logic [DW-1:0]     outData,
    output logic [CW-1:0]     outChan,
    input  logic              inReady,
    output logic [AW:0]       outCount
);

    localparam logic        ST_IDLE  = 1'b0;
    localparam logic        ST_ACK   = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Request synchronisers
    // ------------------------------------------------------------------
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] req_s;

    always_ff @(posedge clkPER or negedge rstPER) begin
        if (!rstPER) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= inSend;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NCH-1:0]      st_q, st_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [AW:0]         count_q, count_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]       head_dat_q, head_dat_d;
    logic [CW-1:0]       head_chan_q, head_chan_d;
    logic [CW+DW-1:0]    mem_q [DEPTH];

    logic                pop;
    logic                space;
    logic [NCH-1:0]      req_w;
    logic                gnt_vld;
    logic [CW-1:0]       gnt_idx;
    logic [DW-1:0]       gnt_dat;
    logic                par_bad;
    logic                push;

    assign pop   = (count_q != '0) && inReady;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign space = (count_q != FULL_CNT) || pop;

    // ------------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last granted channel.
    // rr_q resets to NCH-1 so the first search starts at channel 0.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NCH; c++) req_w[c] = req_s[c] && (st_q[c] == ST_IDLE);
    end

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld && req_w[idx] && space) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
    end

    // inData is stable while inSend is high, so it is sampled without synchronisation.
    assign gnt_dat = inData[gnt_idx*DW +: DW];

`ifdef PER_PARITY_EN
    logic err_q;

    assign par_bad = gnt_vld && ((^gnt_dat) != inParity[gnt_idx]);

    always_ff @(posedge clkPER or negedge rstPER) begin
        if (!rstPER)      err_q <= 1'b0;
        else if (par_bad) err_q <= 1'b1;
    end

    assign outParErr = err_q;
`else
    assign par_bad = 1'b0;
`endif

    // A bad-parity capture still uses the grant and completes the handshake.
    assign push = gnt_vld && !par_bad;
    assign rr_d = gnt_vld ? gnt_idx : rr_q;

    // ------------------------------------------------------------------
    // Per-channel handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        st_d = st_q;
        for (int c = 0; c < NCH; c++) begin
            if (st_q[c] == ST_IDLE) begin
                if (gnt_vld && (int'(gnt_idx) == c)) st_d[c] = ST_ACK;
            end else begin
                if (!req_s[c]) st_d[c] = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO with registered head
    // ------------------------------------------------------------------
    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // When nothing else remains ahead of it, the pushed word becomes the head directly;
    // otherwise the head reloads from storage. Empty: head holds its last value.
    always_comb begin
        head_dat_d  = head_dat_q;
        head_chan_d = head_chan_q;
        if (push && ((count_q - {{AW{1'b0}}, pop}) == '0)) begin
            head_dat_d  = gnt_dat;
            head_chan_d = gnt_idx;
        end else if (count_d != '0) begin
            {head_chan_d, head_dat_d} = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clkPER) begin
        if (push) mem_q[wr_ptr_q] <= {gnt_idx, gnt_dat};
    end

    always_ff @(posedge clkPER or negedge rstPER) begin
        if (!rstPER) begin
            st_q        <= {NCH{ST_IDLE}};
            rr_q        <= CW'(NCH - 1);
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_dat_q  <= '0;
            head_chan_q <= '0;
        end else begin
            st_q        <= st_d;
            rr_q        <= rr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_dat_q  <= head_dat_d;
            head_chan_q <= head_chan_d;
        end
    end

    assign outAck   = st_q;
    assign outValid = (count_q != '0);
    assign outData  = head_dat_q;
    assign outChan  = head_chan_q;
    assign outCount = count_q;

endmodule
